flag_cross_arbiter: RTL and testbench
=====================================

# flag_cross_arbiter

Source-side scheduler that shares one acknowledged flag-crossing channel (toggle flag + 2-flop return-busy synchronizer) between N requesters in the same clock domain. It latches request pulses, grants round-robin, registers the winner's data word onto a shared bus held stable for the whole crossing, issues a one-cycle flag to the channel, and waits for the channel's busy to rise and fall before returning a per-requester done pulse. It sits between multiple clk_a-side producers and a single flag_cross_domain_ack-style channel instance.

## Interface
- N, 4, number of requesters (2..16)
- DATA_W, 8, width of data word carried alongside each flag
- TIMEOUT, 255, cycles allowed per wait state before abort (used only with timeout feature)
- clk  input  1  single clock; all logic on posedge
- rst  input  1  asynchronous, active-high reset
- req_i  input  N  per-requester one-cycle request pulse
- data_i  input  N*DATA_W  requester k's word at bits [k*DATA_W +: DATA_W]; held stable by requester from req until done
- pend_o  output  N  request latched, not yet completed
- done_o  output  N  one-cycle completion pulse to requester
- grant_id_o  output  clog2(N)  index of current/last granted requester
- active_o  output  1  high while state != IDLE
- chan_flag_o  output  1  one-cycle flag to channel input
- chan_data_o  output  DATA_W  registered word, stable from flag until busy falls
- chan_busy_i  input  1  channel busy (already in this clock domain)
- timeout_o  output  1  one-cycle abort pulse

## Operation
- Reset: pend_o, done_o, grant_id_o, chan_flag_o, chan_data_o, timeout_o = 0; active_o = 0; state IDLE; round-robin pointer = N-1 (requester 0 wins first).
- Pending: req_i[k] sets pend[k] next edge; pend[k] cleared on DONE or abort for k. Set and clear same cycle: set wins (request re-queued). req_i[k] while pend[k]=1 and not clearing: absorbed, no second transfer.
- Arbitration (IDLE, any pend): winner = first set bit searching from pointer+1, wrapping modulo N. On that edge: grant_id_o <= winner, pointer <= winner, chan_data_o <= data_i slice, state -> LAUNCH.
- States:
  - IDLE: wait for any pend bit.
  - LAUNCH: chan_flag_o = 1 (registered, exactly one cycle); -> WAIT_HI.
  - WAIT_HI: wait chan_busy_i = 1; -> WAIT_LO.
  - WAIT_LO: wait chan_busy_i = 0; -> DONE.
  - DONE: done_o[grant_id_o] = 1 one cycle, clear pend; -> IDLE.
- chan_data_o changes only on a grant edge; never while busy.
- chan_busy_i high while IDLE (foreign activity): no grant until it is low.

## Timing
- req_i pulse at cycle t -> pend_o at t+1 -> grant edge end of t+1 -> chan_flag_o high t+2 -> earliest WAIT_HI exit t+3.
- done_o asserted the cycle after busy observed low in WAIT_LO; IDLE the following cycle; next grant earliest one cycle after that.
- Back-to-back throughput: one transfer per (busy high duration + 5) cycles.
- rst mid-transfer: all state cleared immediately; pending requests lost; channel may still complete the toggle, requesters must re-issue.

## Configuration
- FLAG_ARB_TIMEOUT_EN defined: counter, width clog2(TIMEOUT+1), clears on entry to WAIT_HI/WAIT_LO, increments each cycle there; reaching TIMEOUT -> timeout_o pulse one cycle, pend[grant] cleared, no done_o, state -> IDLE, pointer advances normally.
- Not defined: no counter; WAIT states wait indefinitely; timeout_o tied 0.

## Test plan
- Single request: req_i=4'b0010, data_i slice1=8'hA5, busy high 4 cycles from t+3 -> chan_flag_o at t+2 only, chan_data_o=8'hA5 stable through busy, done_o=4'b0010 one cycle, pend_o back to 0.
- Simultaneous: req_i=4'b1111 after reset -> grant order 0,1,2,3, four done pulses, each chan_data_o matches its slice.
- Fairness: requester 0 re-requests in every DONE cycle while 2 pending -> grants alternate 0,2,0,2; set-wins keeps 0 pending.
- Duplicate pulse: req_i[3] twice while pend[3]=1 -> exactly one flag, one done_o[3].
- Reset during WAIT_LO (busy high): rst pulse -> all outputs 0, state IDLE next cycle, no done_o.
- With FLAG_ARB_TIMEOUT_EN, TIMEOUT=8, busy held high -> timeout_o pulse 8 cycles after WAIT_LO entry, no done_o, next requester granted once busy low.

Source files
------------

// File: rtl/flag_cross_arbiter_if.sv
// Handshake/bus bundle between N requesters, the arbiter and one flag channel.
// slave: arbiter side (flag_cross_arbiter); master: requesters + channel side.
//   req_i/data_i        requester pulses and their data words
//   pend_o/done_o       per-requester pending flags and completion pulses
//   grant_id_o/active_o current grant index and busy-scheduling indicator
//   chan_flag_o/chan_data_o/chan_busy_i  shared channel connection
//   timeout_o           abort pulse (only meaningful with FLAG_ARB_TIMEOUT_EN)
interface flag_cross_arbiter_if #(
    parameter int N      = 4,
    parameter int DATA_W = 8
);
    localparam int IW = $clog2(N);

    logic [N-1:0]        req_i;
    logic [N*DATA_W-1:0] data_i;
    logic [N-1:0]        pend_o;
    logic [N-1:0]        done_o;
    logic [IW-1:0]       grant_id_o;
    logic                active_o;
    logic                chan_flag_o;
    logic [DATA_W-1:0]   chan_data_o;
    logic                chan_busy_i;
    logic                timeout_o;

    modport slave (
        input  req_i, data_i, chan_busy_i,
        output pend_o, done_o, grant_id_o, active_o,
        output chan_flag_o, chan_data_o, timeout_o
    );

    modport master (
        output req_i, data_i, chan_busy_i,
        input  pend_o, done_o, grant_id_o, active_o,
        input  chan_flag_o, chan_data_o, timeout_o
    );
endinterface

// File: rtl/flag_cross_arbiter.sv
// Round-robin scheduler sharing one acknowledged flag-crossing channel among
// N same-domain requesters. Ports: clk, rst (async, active-high), bus (slave
// modport of flag_cross_arbiter_if). Optional macro FLAG_ARB_TIMEOUT_EN adds a
// per-wait-state abort after TIMEOUT cycles; without it timeout_o is tied 0.
module flag_cross_arbiter #(
    parameter int N       = 4,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    flag_cross_arbiter_if.slave  bus
);
    localparam int IW = $clog2(N);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LAUNCH  = 3'd1;
    localparam logic [2:0] S_WAIT_HI = 3'd2;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    if (N < 2 || N > 16 || TIMEOUT < 1) begin : g_param_chk
        $error("flag_cross_arbiter: parameter out of range");
    end

    logic [2:0]        state_q, state_d;
    logic [N-1:0]      pend_q, pend_d;
    logic [N-1:0]      done_q, done_d;
    logic [IW-1:0]     grant_q, grant_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic              flag_q, flag_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic [N-1:0]      clr;
    logic [N-1:0]      gsel;
    logic [IW-1:0]     win;
    logic [IW-1:0]     idx;
    logic              found;
    logic [DATA_W-1:0] win_data;

`ifdef FLAG_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    logic          tmo_hit;
    assign tmo_hit = (cnt_q == CW'(TIMEOUT - 1));
`endif

    // Round-robin: first pending bit after the last winner, wrapping.
    always_comb begin
        win   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(ptr_q) + i) % N);
            if (!found && pend_q[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int k = 0; k < N; k++) begin
            if (win == IW'(k)) begin
                win_data = bus.data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    assign gsel = {{(N-1){1'b0}}, 1'b1} << grant_q;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        data_d  = data_q;
        flag_d  = 1'b0;
        done_d  = '0;
        clr     = '0;
`ifdef FLAG_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // Busy while idle means the channel is still finishing a
                // toggle we no longer own; hold off until it settles.
                if (found && !bus.chan_busy_i) begin
                    grant_d = win;
                    ptr_d   = win;
                    data_d  = win_data;
                    flag_d  = 1'b1;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT_HI;
`ifdef FLAG_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT_HI: begin
                if (bus.chan_busy_i) begin
                    state_d = S_WAIT_LO;
`ifdef FLAG_ARB_TIMEOUT_EN
                    cnt_d   = '0;
                end else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    clr     = gsel;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            S_WAIT_LO: begin
                if (!bus.chan_busy_i) begin
                    done_d  = gsel;
                    state_d = S_DONE;
`ifdef FLAG_ARB_TIMEOUT_EN
                end else if (tmo_hit) begin
                    tmo_d   = 1'b1;
                    clr     = gsel;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            S_DONE: begin
                clr     = gsel;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A new pulse in the clearing cycle re-queues the requester.
        pend_d = (pend_q & ~clr) | bus.req_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pend_q  <= '0;
            done_q  <= '0;
            grant_q <= '0;
            ptr_q   <= IW'(N - 1);
            flag_q  <= 1'b0;
            data_q  <= '0;
`ifdef FLAG_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            flag_q  <= flag_d;
            data_q  <= data_d;
`ifdef FLAG_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.pend_o      = pend_q;
    assign bus.done_o      = done_q;
    assign bus.grant_id_o  = grant_q;
    assign bus.active_o    = (state_q != S_IDLE);
    assign bus.chan_flag_o = flag_q;
    assign bus.chan_data_o = data_q;
`ifdef FLAG_ARB_TIMEOUT_EN
    assign bus.timeout_o   = tmo_q;
`else
    assign bus.timeout_o   = 1'b0;
`endif
endmodule

// File: tb/tb_flag_cross_arbiter.sv
// Directed bench for flag_cross_arbiter: vector table for a single transfer,
// plus sequences for multi-request, fairness, duplicates, reset and timeout.
module tb_flag_cross_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
`ifdef FLAG_ARB_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    flag_cross_arbiter_if #(.N(N), .DATA_W(DW)) bus();

    flag_cross_arbiter #(.N(N), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic man_busy = 1'b0;
    logic auto_en  = 1'b0;
    logic auto_busy;
    int   hold_len = 2;
    int   acnt;
    assign bus.chan_busy_i = auto_en ? auto_busy : man_busy;

    // Channel model: busy rises the cycle after the flag, stays hold_len cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_busy <= 1'b0;
            acnt      <= 0;
        end else if (bus.chan_flag_o) begin
            auto_busy <= 1'b1;
            acnt      <= hold_len;
        end else if (acnt > 1) begin
            acnt      <= acnt - 1;
        end else begin
            auto_busy <= 1'b0;
            acnt      <= 0;
        end
    end

    logic [1:0] glog[$];
    logic [7:0] dlog[$];
    logic [3:0] donelog[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.chan_flag_o) begin
                glog.push_back(bus.grant_id_o);
                dlog.push_back(bus.chan_data_o);
            end
            if (|bus.done_o) donelog.push_back(bus.done_o);
        end
    end

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {11'd0, bus.pend_o, bus.done_o, bus.chan_flag_o,
                bus.active_o, bus.grant_id_o, bus.chan_data_o,
                bus.timeout_o};
    endfunction

    typedef struct {
        logic [3:0] req;
        logic       busy;
        logic [3:0] pend;
        logic [3:0] done;
        logic       flag;
        logic       act;
        logic [1:0] gid;
        logic [7:0] cd;
    } vec_t;

    vec_t tv[10];

    task automatic do_reset();
        rst         = 1'b1;
        bus.req_i   = '0;
        man_busy    = 1'b0;
        auto_en     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int dbase;
        int n0;
        int n2;
        int c;
        logic chkpend;

        bus.req_i  = '0;
        bus.data_i = '0;

        tv[0] = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b0, 2'd0, 8'h00};
        tv[1] = '{4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b1, 1'b1, 2'd1, 8'hA5};
        tv[2] = '{4'b0000, 1'b0, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 8'hA5};
        tv[3] = '{4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 8'hA5};
        tv[4] = '{4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 8'hA5};
        tv[5] = '{4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 8'hA5};
        tv[6] = '{4'b0000, 1'b1, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd1, 8'hA5};
        tv[7] = '{4'b0000, 1'b0, 4'b0010, 4'b0010, 1'b0, 1'b1, 2'd1, 8'hA5};
        tv[8] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 8'hA5};
        tv[9] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd1, 8'hA5};

        // Reset state
        do_reset();
        chk("reset_state", outs(), 32'd0);

        // Single request, vector table
        bus.data_i = 32'h0000_A500;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.req_i = tv[i].req;
            man_busy  = tv[i].busy;
            @(posedge clk);
            #1;
            chk($sformatf("single_v%0d", i), outs(),
                {11'd0, tv[i].pend, tv[i].done, tv[i].flag, tv[i].act,
                 tv[i].gid, tv[i].cd, 1'b0});
        end
        @(negedge clk);
        bus.req_i = '0;

        // Simultaneous requests: grant order 0,1,2,3
        do_reset();
        auto_en    = 1'b1;
        hold_len   = 2;
        bus.data_i = 32'h4433_2211;
        base  = glog.size();
        dbase = donelog.size();
        @(negedge clk);
        bus.req_i = 4'b1111;
        @(negedge clk);
        bus.req_i = 4'b0000;
        c = 0;
        while (c < 200 && donelog.size() - dbase < 4) begin
            @(negedge clk);
            c++;
        end
        chk("sim_done_count", donelog.size() - dbase, 4);
        if (glog.size() - base >= 4 && donelog.size() - dbase >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("sim_gid%0d", k), glog[base+k], k);
                chk($sformatf("sim_data%0d", k), dlog[base+k], 8'h11 * (k + 1));
                chk($sformatf("sim_donev%0d", k), donelog[dbase+k], 1 << k);
            end
        end

        // Fairness: 0 and 2 re-request in their DONE cycles
        do_reset();
        auto_en  = 1'b1;
        hold_len = 2;
        base     = glog.size();
        n0       = 0;
        n2       = 0;
        chkpend  = 1'b0;
        @(negedge clk);
        bus.req_i = 4'b0101;
        c = 0;
        while (c < 300) begin
            @(negedge clk);
            c++;
            bus.req_i = 4'b0000;
            if (chkpend) begin
                chk("fair_setwins", bus.pend_o, 4'b0101);
                chkpend = 1'b0;
            end
            if (bus.done_o[0] && n0 < 2) begin
                bus.req_i[0] = 1'b1;
                n0++;
                if (n0 == 1) chkpend = 1'b1;
            end
            if (bus.done_o[2] && n2 < 2) begin
                bus.req_i[2] = 1'b1;
                n2++;
            end
            if (glog.size() - base >= 6 && bus.pend_o == 0 && !bus.active_o)
                break;
        end
        bus.req_i = '0;
        chk("fair_count", glog.size() - base, 6);
        if (glog.size() - base >= 6) begin
            for (int k = 0; k < 6; k++) begin
                chk($sformatf("fair_gid%0d", k), glog[base+k],
                    (k % 2) ? 2 : 0);
            end
        end

        // Duplicate pulses while pending are absorbed
        do_reset();
        auto_en    = 1'b1;
        hold_len   = 3;
        bus.data_i = 32'h7700_0000;
        base  = glog.size();
        dbase = donelog.size();
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.req_i = (k % 2 == 0) ? 4'b1000 : 4'b0000;
        end
        for (int k = 0; k < 40; k++) @(negedge clk);
        chk("dup_flags", glog.size() - base, 1);
        chk("dup_dones", donelog.size() - dbase, 1);
        if (donelog.size() - dbase >= 1)
            chk("dup_done_bit", donelog[dbase], 4'b1000);
        chk("dup_pend", bus.pend_o, 4'b0000);

        // Reset in WAIT_LO with busy high
        do_reset();
        dbase = donelog.size();
        bus.data_i = 32'h0000_00C3;
        @(negedge clk);
        bus.req_i = 4'b0001;
        @(negedge clk);
        bus.req_i = 4'b0000;
        @(negedge clk);
        man_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_active", {bus.active_o, bus.chan_data_o}, 9'h1C3);
        rst = 1'b1;
        #1;
        chk("rst_async_clear", outs(), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k == 3) man_busy = 1'b0;
        end
        chk("rst_no_done", donelog.size() - dbase, 0);
        chk("rst_idle", {bus.active_o, bus.pend_o}, 5'd0);

`ifdef FLAG_ARB_TIMEOUT_EN
        // Timeout with busy stuck high, then next requester once busy drops
        do_reset();
        dbase = donelog.size();
        @(negedge clk);
        bus.req_i = 4'b0011;
        @(negedge clk);
        bus.req_i = 4'b0000;
        @(negedge clk);
        man_busy = 1'b1;
        c = 0;
        while (c < 50) begin
            @(negedge clk);
            c++;
            if (bus.timeout_o) break;
        end
        chk("tmo_delay", c, 10);
        chk("tmo_pend", bus.pend_o, 4'b0010);
        @(negedge clk);
        chk("tmo_one_cycle", bus.timeout_o, 1'b0);
        man_busy = 1'b0;
        c = 0;
        while (c < 20 && !bus.chan_flag_o) begin
            @(negedge clk);
            c++;
        end
        chk("tmo_next_grant", {bus.chan_flag_o, bus.grant_id_o}, 3'b101);
        chk("tmo_no_done", donelog.size() - dbase, 0);
        for (int k = 0; k < 10; k++) @(negedge clk);
        man_busy = 1'b0;
`endif

        chk("timeout_idle_low", bus.timeout_o, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
